// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the MEM-stage memory access controller:
//   FSM state encoding, datapath width and the default abort timeout.
package mem_access_ctrl_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// mem_timeout_cnt
//   8-bit wait counter for the REQ phase. terminal is high while the current
//   cycle is the LIMIT-th consecutive enabled cycle since the last clear, so a
//   request that is still unacked in that cycle is aborted at its end.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to zero (held while not waiting on memory)
//   enable     : count this cycle (waiting and no ack)
//   terminal   : count has reached LIMIT-1
module mem_timeout_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign terminal = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences the MEM stage around a variable-latency data memory with a
//   req/ack handshake. Each load or store seen on the EX/MEM register runs
//   IDLE -> REQ -> DONE; the upstream pipeline is frozen (stall) from the
//   IDLE detect cycle through the last REQ cycle, and released for exactly one
//   cycle in DONE so MEM/WB captures readDataMEM and EX/MEM advances.
//
// Handshake: dmemReq is raised on entry to REQ and held with dmemAddr,
//   dmemWdata and dmemWe stable until a cycle in which dmemAck=1 is sampled
//   on the rising edge; that edge completes the transfer (read data is taken
//   from dmemRdata in the same cycle) and dmemReq drops in DONE. dmemAck is
//   ignored whenever dmemReq is low.
//
// Optional feature (macro MEM_ACCESS_TIMEOUT_EN): abort a request that is not
//   acked within TIMEOUT_CYCLES REQ cycles, load readDataMEM with 0 and set a
//   sticky memError. Without the macro REQ waits indefinitely, memError = 0.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   memReadMEM       : load in MEM stage
//   memWriteMEM      : store in MEM stage (wins if both are set)
//   aluResultMEM     : effective address
//   regReadData2MEM  : store data
//   dmemAck/Rdata    : memory completion and load data
//   dmemReq/We/Addr/Wdata : memory request side (registered)
//   readDataMEM      : load result to MEM/WB (holds between loads)
//   stall            : freeze PC..EX/MEM, bubble MEM/WB (combinational)
//   memError         : sticky timeout flag
//   dbgState         : current FSM state
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memReadMEM,
  input  logic              memWriteMEM,
  input  logic [DATA_W-1:0] aluResultMEM,
  input  logic [DATA_W-1:0] regReadData2MEM,
  input  logic              dmemAck,
  input  logic [DATA_W-1:0] dmemRdata,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [DATA_W-1:0] dmemAddr,
  output logic [DATA_W-1:0] dmemWdata,
  output logic [DATA_W-1:0] readDataMEM,
  output logic              stall,
  output logic              memError,
  output state_t            dbgState
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t state;
  logic   access;

  assign access = memReadMEM | memWriteMEM;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic timeoutHit;

  // Counter is cleared outside REQ, so it restarts on every REQ entry.
  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) uTimeoutCnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != REQ),
    .enable   ((state == REQ) && !dmemAck),
    .terminal (timeoutHit)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dmemReq     <= 1'b0;
      dmemWe      <= 1'b0;
      dmemAddr    <= '0;
      dmemWdata   <= '0;
      readDataMEM <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      memError    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dmemAddr  <= aluResultMEM;
            dmemWdata <= regReadData2MEM;
            dmemWe    <= memWriteMEM;
            dmemReq   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // An ack in the timeout cycle takes priority: normal completion.
          if (dmemAck) begin
            if (!dmemWe) begin
              readDataMEM <= dmemRdata;
            end
            dmemReq <= 1'b0;
            state   <= DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (timeoutHit) begin
            memError    <= 1'b1;
            readDataMEM <= '0;
            dmemReq     <= 1'b0;
            state       <= DONE;
          end
`endif
        end
        // EX/MEM still shows the finished instruction here; returning to IDLE
        // unconditionally keeps it from being issued a second time.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_ACCESS_TIMEOUT_EN
  assign memError = 1'b0;
`endif

  assign stall    = ((state == IDLE) && access) || (state == REQ);
  assign dbgState = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Scoreboard bench for mem_access_ctrl. The main process issues
//   instructions like the EX/MEM register would (advancing only when stall is
//   low) and pushes the expected memory request and completion into queues.
//   A memory responder acks after a chosen latency; a monitor pops and
//   compares whenever a request starts or completes.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 4;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 64;
`endif
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memReadMEM, memWriteMEM;
  logic [31:0] aluResultMEM, regReadData2MEM;
  logic        dmemAck;
  logic [31:0] dmemRdata;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata, readDataMEM;
  logic        stall, memError;
  state_t      dbgState;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .memReadMEM      (memReadMEM),
    .memWriteMEM     (memWriteMEM),
    .aluResultMEM    (aluResultMEM),
    .regReadData2MEM (regReadData2MEM),
    .dmemAck         (dmemAck),
    .dmemRdata       (dmemRdata),
    .dmemReq         (dmemReq),
    .dmemWe          (dmemWe),
    .dmemAddr        (dmemAddr),
    .dmemWdata       (dmemWdata),
    .readDataMEM     (readDataMEM),
    .stall           (stall),
    .memError        (memError),
    .dbgState        (dbgState)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking core ----------------
  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Expected queues: request = {we, addr, wdata}; done = {err, stallCycles, readData}
  logic [64:0] expReqQ[$];
  logic [40:0] expDoneQ[$];
  int          latQ[$];
  logic [31:0] rdQ[$];

  // Reference model state
  logic [31:0] lastRead = '0;
  logic        expErr   = 1'b0;

  // ---------------- memory responder ----------------
  bit          busy = 0;
  int          cnt, curLat;
  logic [31:0] curRd;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy      = 0;
      dmemAck   = 1'b0;
      dmemRdata = $urandom;
    end else if (dmemReq) begin
      if (!busy) begin
        busy = 1;
        cnt  = 0;
        if (latQ.size() > 0) begin
          curLat = latQ.pop_front();
          curRd  = rdQ.pop_front();
        end else begin
          curLat = NEVER;
          curRd  = '0;
        end
      end else begin
        cnt++;
      end
      dmemAck   = (cnt == curLat);
      dmemRdata = dmemAck ? curRd : $urandom;
    end else begin
      // Noise on ack/rdata while no request is outstanding must be ignored.
      busy      = 0;
      dmemAck   = 1'($urandom_range(0, 1));
      dmemRdata = $urandom;
    end
  end

  // ---------------- monitor ----------------
  logic        prevReq  = 1'b0;
  int          stallRun = 0;
  logic [64:0] curReq;
  logic [40:0] curDone;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevReq  = 1'b0;
      stallRun = 0;
    end else begin
      if (!memReadMEM && !memWriteMEM)
        chk("nonmem_no_stall_req", {stall, dmemReq}, 2'b00);

      if (dmemReq && !prevReq) begin
        if (expReqQ.size() == 0) begin
          chk("unexpected_request", 1'b1, 1'b0);
          curReq = {dmemWe, dmemAddr, dmemWdata};
        end else begin
          curReq = expReqQ.pop_front();
          chk("req_we",    dmemWe,    curReq[64]);
          chk("req_addr",  dmemAddr,  curReq[63:32]);
          chk("req_wdata", dmemWdata, curReq[31:0]);
        end
      end else if (dmemReq) begin
        chk("req_hold", {dmemWe, dmemAddr, dmemWdata}, curReq);
      end

      if (stall) stallRun++;

      if (!dmemReq && prevReq) begin
        if (expDoneQ.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          curDone = expDoneQ.pop_front();
          chk("done_stall_low",   stall,       1'b0);
          chk("done_stall_count", stallRun,    curDone[39:32]);
          chk("done_read_data",   readDataMEM, curDone[31:0]);
          chk("done_mem_error",   memError,    curDone[40]);
        end
      end
      if (!stall) stallRun = 0;
      prevReq = dmemReq;
    end
  end

  // ---------------- driver ----------------
  // Present one instruction on EX/MEM and hold it until a stall-free cycle
  // lets the pipeline advance past it.
  task automatic runInstr(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int lat,
                          input logic [31:0] rdata);
    bit done = 0;
    int stallN;
    if (rd || wr) begin
      expReqQ.push_back({wr, addr, data});
      latQ.push_back(lat);
      rdQ.push_back(rdata);
      if (TMO_EN && lat >= TMO) begin
        expErr   = 1'b1;
        lastRead = '0;
        stallN   = TMO + 1;
      end else begin
        if (!wr) lastRead = rdata;
        stallN = lat + 2;
      end
      expDoneQ.push_back({expErr, 8'(stallN), lastRead});
    end
    memReadMEM      = rd;
    memWriteMEM     = wr;
    aluResultMEM    = addr;
    regReadData2MEM = data;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
    end
    chk("instr_advanced", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_dmemReq"},     dmemReq,     1'b0);
    chk({tag, "_dmemWe"},      dmemWe,      1'b0);
    chk({tag, "_dmemAddr"},    dmemAddr,    32'h0);
    chk({tag, "_dmemWdata"},   dmemWdata,   32'h0);
    chk({tag, "_readDataMEM"}, readDataMEM, 32'h0);
    chk({tag, "_memError"},    memError,    1'b0);
    chk({tag, "_state"},       dbgState,    IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    memReadMEM      = 1'b0;
    memWriteMEM     = 1'b0;
    aluResultMEM    = '0;
    regReadData2MEM = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    chk("reset_stall", stall, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load, ack in the third REQ cycle: 4 stall cycles.
    runInstr(1, 0, 32'h100, 32'h0, 2, 32'hCAFEF00D);
    // Store, zero-wait ack: 2 stall cycles, readDataMEM unchanged.
    runInstr(0, 1, 32'h20, 32'h12345678, 0, 32'hDEADBEEF);
    // Ten non-memory instructions.
    for (int i = 0; i < 10; i++) runInstr(0, 0, $urandom, $urandom, 0, 0);
    // Back-to-back load then store.
    runInstr(1, 0, 32'h40, 32'h0, 0, 32'h0BADC0DE);
    runInstr(0, 1, 32'h44, 32'hA5A5A5A5, 0, 32'h11111111);
    // Read and write together behaves as a write.
    runInstr(1, 1, 32'h48, 32'h5A5A5A5A, 1, 32'h22222222);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Never-acked load aborts after TMO REQ cycles; error stays set.
    runInstr(1, 0, 32'h80, 32'h0, NEVER, 32'h33333333);
    runInstr(1, 0, 32'h84, 32'h0, TMO - 1, 32'h44444444);
    runInstr(0, 0, 32'h0, 32'h0, 0, 0);
    chk("mem_error_sticky", memError, 1'b1);
`endif

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      int          kind;
      int          lat;
      logic [31:0] a, d, r;
      kind = $urandom_range(0, 4);
      lat  = TMO_EN ? $urandom_range(0, TMO + 1) : $urandom_range(0, 6);
      a    = $urandom;
      d    = $urandom;
      r    = $urandom;
      runInstr(kind == 1 || kind == 2 || kind == 4, kind >= 3, a, d, lat, r);
    end

    // Reset during the second REQ cycle of a slow load.
    latQ.push_back(10);
    rdQ.push_back(32'h55555555);
    expReqQ.push_back({1'b0, 32'h200, 32'h66666666});
    memReadMEM      = 1'b1;
    memWriteMEM     = 1'b0;
    aluResultMEM    = 32'h200;
    regReadData2MEM = 32'h66666666;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    memReadMEM = 1'b0;
    lastRead   = '0;
    expErr     = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("postreset");
    chk("postreset_stall", stall, 1'b0);
    @(posedge clk);
    #1;

    // Normal operation resumes after reset.
    runInstr(1, 0, 32'h300, 32'h0, 1, 32'h77777777);
    runInstr(0, 1, 32'h304, 32'h88888888, 0, 32'h0);
    for (int i = 0; i < 3; i++) runInstr(0, 0, 32'h0, 32'h0, 0, 0);

    chk("exp_req_q_empty",  expReqQ.size(),  0);
    chk("exp_done_q_empty", expDoneQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", nChecks);
    $fatal(1, "watchdog");
  end

endmodule
